// File: rtl/aes_out_collector.sv
// Output collector for the interleaved AES datapath: tags each finished
// ciphertext with its context index and buffers it in a first-word-fall-through
// FIFO that drains over a valid/ready handshake.
module aes_out_collector #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     done_i,
  input  logic [127:0]             data_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_data,
  output logic [CW-1:0]            out_ctx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [127:0]   mem_data_q [DEPTH];
  logic [CW-1:0]  mem_ctx_q  [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q,  count_d;
  logic [CW-1:0]   ctx_q,    ctx_d;
  logic            overflow_q, overflow_d;
  logic            wr;
  logic            rd;

  // Status and head presentation straight from registered state.
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNTW'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_data  = mem_data_q[rd_ptr_q];
  assign out_ctx   = mem_ctx_q[rd_ptr_q];

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign rd = out_valid & out_ready;
  assign wr = done_i & start & (~full | rd);

  // Next-state: context tag, pointers, occupancy, sticky overflow.
  always_comb begin
    ctx_d      = ctx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (!start) begin
      ctx_d = '0;
    end else if (done_i) begin
      ctx_d = (ctx_q == CW'(N - 1)) ? '0 : CW'(ctx_q + CW'(1));
    end

    if (wr) wr_ptr_d = AW'(wr_ptr_q + AW'(1));
    if (rd) rd_ptr_d = AW'(rd_ptr_q + AW'(1));

    unique case ({wr, rd})
      2'b10:   count_d = CNTW'(count_q + CNTW'(1));
      2'b01:   count_d = CNTW'(count_q - CNTW'(1));
      default: count_d = count_q;
    endcase

    if (done_i && start && full && !rd) overflow_d = 1'b1;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ctx_q      <= ctx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data_q[wr_ptr_q] <= data_i;
      mem_ctx_q[wr_ptr_q]  <= ctx_q;
    end
  end

endmodule

// File: tb/tb_aes_out_collector.sv
// Directed bench for aes_out_collector (N=4, DEPTH=8).
module tb_aes_out_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done_i;
  logic [127:0] data_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [1:0]   out_ctx;
  logic [3:0]   count;
  logic         full;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] DA = 128'hA;
  localparam logic [127:0] DB = 128'hB;
  localparam logic [127:0] DC = 128'hC;
  localparam logic [127:0] DD = 128'hD;
  localparam logic [127:0] DE = 128'hE0E0;
  localparam logic [127:0] DX = 128'hDEAD;
  localparam logic [127:0] D1 = 128'h11111111111111111111111111111111;

  aes_out_collector #(.N(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done_i    (done_i),
    .data_i    (data_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctx   (out_ctx),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [127:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_ctx"},   128'(out_ctx), 128'(c));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; done_i = 1'b0; data_i = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_full",  128'(full), 128'(0));
    chk("rst_ovf",   128'(overflow), 128'(0));

    // Single batch with consumer ready: one-deep pass-through.
    start = 1'b1; out_ready = 1'b1; done_i = 1'b1;
    data_i = DA; tick(); chk_head("b1_A", DA, 2'd0); chk("b1_cntA", 128'(count), 128'(1));
    data_i = DB; tick(); chk_head("b1_B", DB, 2'd1); chk("b1_cntB", 128'(count), 128'(1));
    data_i = DC; tick(); chk_head("b1_C", DC, 2'd2); chk("b1_cntC", 128'(count), 128'(1));
    data_i = DD; tick(); chk_head("b1_D", DD, 2'd3); chk("b1_cntD", 128'(count), 128'(1));
    done_i = 1'b0; tick();
    chk("b1_empty", 128'(out_valid), 128'(0));
    chk("b1_ovf",   128'(overflow), 128'(0));

    // Stalled consumer: two batches fill the FIFO.
    out_ready = 1'b0; done_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_i = 128'(32'h100 + i);
      tick();
    end
    chk("fill_count", 128'(count), 128'(8));
    chk("fill_full",  128'(full), 128'(1));
    chk_head("fill_head", 128'h100, 2'd0);

    // One more result while full and stalled is dropped.
    data_i = DX; tick();
    chk("ovf_set",   128'(overflow), 128'(1));
    chk("ovf_count", 128'(count), 128'(8));
    done_i = 1'b0; tick();
    chk("ovf_sticky", 128'(overflow), 128'(1));
    chk_head("ovf_head", 128'h100, 2'd0);

    // Full with simultaneous read: E written (tag 1, ctx advanced past drop).
    out_ready = 1'b1; done_i = 1'b1; data_i = DE; tick();
    chk("fr_count", 128'(count), 128'(8));
    chk("fr_ovf",   128'(overflow), 128'(1));
    chk_head("fr_head", 128'h101, 2'd1);

    // Stall holds head stable.
    done_i = 1'b0; out_ready = 1'b0; tick(); tick();
    chk_head("stall_head", 128'h101, 2'd1);

    // Drain the rest in order.
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk_head("drain", 128'(32'h100 + i), 2'(i % 4));
      tick();
    end
    chk_head("drain_E", DE, 2'd1);
    tick();
    chk("drain_empty", 128'(count), 128'(0));
    chk("drain_valid", 128'(out_valid), 128'(0));

    // Abort mid-batch: ctx clears, captured entries retained.
    start = 1'b0; out_ready = 1'b0; tick();
    start = 1'b1; done_i = 1'b1;
    data_i = 128'hF0; tick();
    data_i = 128'hF1; tick();
    start = 1'b0; data_i = 128'hF2; tick(); tick();
    done_i = 1'b0;
    chk("ab_count", 128'(count), 128'(2));
    chk_head("ab_h0", 128'hF0, 2'd0);
    out_ready = 1'b1; tick();
    chk_head("ab_h1", 128'hF1, 2'd1);
    tick();
    chk("ab_empty", 128'(count), 128'(0));
    out_ready = 1'b0; start = 1'b1; done_i = 1'b1; data_i = 128'hF3; tick();
    chk_head("ab_next", 128'hF3, 2'd0);

    // Reset mid-burst with three entries queued.
    data_i = 128'hF4; tick();
    data_i = 128'hF5; tick();
    chk("pre_rst_count", 128'(count), 128'(3));
    rst = 1'b1; done_i = 1'b0; tick();
    chk("mrst_count", 128'(count), 128'(0));
    chk("mrst_valid", 128'(out_valid), 128'(0));
    chk("mrst_ovf",   128'(overflow), 128'(0));
    rst = 1'b0; done_i = 1'b1; data_i = D1; tick();
    done_i = 1'b0;
    chk_head("post_rst", D1, 2'd0);
    chk("post_rst_count", 128'(count), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_out_collector.md
# aes_out_collector

Output-side collector for the interleaved AES encryption datapath. It sits directly downstream of the AES round controller and core. While the controller's `done` is high, the controller retires one finished context per cycle. The collector captures each finished 128-bit ciphertext, tags it with its context index, and buffers it in a FIFO. The FIFO drains to the consumer over a valid/ready handshake, so results are not lost when the consumer stalls.

## Interface
- `N`, default 4: number of interleaved AES contexts; must match the round controller's `N`.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ N.
- `CW`, default `max(1,$clog2(N))`: context-tag width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  same `start` driven to the round controller; low = idle/abort.
- `done_i`  in  1  controller `done`; high for N consecutive cycles per batch.
- `data_i`  in  128  ciphertext from the AES core; valid on cycles with `done_i`=1.
- `out_valid`  out  1  FIFO head holds an entry.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_data`  out  128  ciphertext at the FIFO head.
- `out_ctx`  out  CW  context index of the head entry.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; a result was dropped.

## Operation
- **Context counter `ctx`** (CW bits):
  - Cleared when `start`=0.
  - Increments on every cycle with `done_i`=1, whether or not the write is accepted.
  - Wraps from N-1 to 0. The k-th result of a batch is therefore tagged k.
- **Write:** `wr = done_i & start & (~full | rd)`. Store `{ctx, data_i}` at `wr_ptr`, then increment `wr_ptr` modulo DEPTH.
- **Read:** `rd = out_valid & out_ready`. Increment `rd_ptr` modulo DEPTH.
- **Occupancy:** `count` changes by +1 on write only, -1 on read only, and 0 on both or neither.
- **Full with simultaneous read:** the write is accepted and the slot freed by the read is reused. `count` stays at DEPTH.
- **Overflow:** if `done_i & start & full & ~rd`, the data is dropped and `overflow` is set. It stays set until `rst`.
- **`done_i` while `start`=0:** ignored. No write, no overflow, `ctx` stays 0.
- **`start` deasserted mid-batch:** `ctx` clears. FIFO contents are retained and continue to drain normally.
- **Output path:** first-word-fall-through. `out_data` and `out_ctx` present `mem[rd_ptr]` combinationally from registered storage. When `out_valid`=0 their values are don't-care.
- **Outputs:** `out_valid = (count != 0)`, `full = (count == DEPTH)`.
- **Reset** (immediate, asynchronous):
  - `wr_ptr`, `rd_ptr`, `count`, `ctx`, `overflow` → 0.
  - Hence `out_valid`=0 and `full`=0.
  - Memory contents are not reset.
- **Pointers:** `$clog2(DEPTH)` bits, natural wrap. `count` is kept separately, not derived from the pointers.

## Timing
- **Write latency:** a result captured at rising edge t appears at the head (`out_valid`=1, if the FIFO was empty) immediately after edge t, i.e. in cycle t+1. There is no added bubble.
- **Read:** the head is consumed at the edge where `out_valid & out_ready`. The next entry is presented in the following cycle.
- **Throughput:** one write and one read per cycle, sustained. A full batch of N results with `out_ready` held high never raises `count` above 1.
- **`out_ready`** may toggle arbitrarily. `out_data`/`out_ctx` must stay stable while `out_valid`=1 and `out_ready`=0.
- **`overflow`** updates on the same edge as the dropped write.

## Test plan
- **Reset:** assert `rst` mid-burst with `count`=3 → next cycle `count`=0, `out_valid`=0, `overflow`=0, `ctx`=0. After release, a new `done_i` pulse with `data_i`=0x11…11 is tagged 0.
- **Single batch, consumer ready:** N=4, `done_i` high 4 cycles with data A,B,C,D and `out_ready`=1 → heads A/0, B/1, C/2, D/3 appear on consecutive cycles, `count` ≤ 1, `overflow`=0.
- **Stalled consumer, fill to full:** DEPTH=8, `out_ready`=0, two batches of 4 → `count`=8, `full`=1. Draining then yields tags 0,1,2,3,0,1,2,3 in order with the correct data.
- **Overflow:** with `full`=1 and `out_ready`=0, one more `done_i` cycle → data dropped, `overflow`=1 and sticky, `count` stays 8, `ctx` still advances.
- **Full with simultaneous read:** `full`=1, `out_ready`=1, `done_i`=1 with data E → head advances, E is written, `count` stays 8, `overflow` unchanged.
- **Abort:** drop `start` after 2 of 4 `done_i` cycles, then pulse `done_i` with `start`=0 → no write and `ctx`=0. The 2 captured entries drain with tags 0,1. The next batch starts at tag 0.
